// File: rtl/seg_hc595_driver.sv
// seg_hc595_driver: serialises seg_dynamic's {seg,sel} into two cascaded 74HC595s.
// A frame is shifted and latched whenever the inputs differ from the last latched frame.
module seg_hc595_driver #(
    parameter int SEL_W   = 6,
    parameter int SEG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int STCP_W  = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEG_W-1:0] seg,
    input  logic             out_en,
    output logic             ds,
    output logic             shcp,
    output logic             stcp,
    output logic             oe_n,
    output logic             busy,
    output logic             frame_done
);
    localparam int N     = SEL_W + SEG_W;
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(N);
    localparam int ST_W  = (STCP_W > 1) ? $clog2(STCP_W) : 1;
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
    localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STCP_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_t;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state, w_state_nxt;
    logic [PH_W-1:0]  r_phase, w_phase_nxt;
    logic [BIT_W-1:0] r_bit, w_bit_nxt;
    logic [ST_W-1:0]  r_st_cnt, w_st_nxt;
    logic [N-1:0]     r_shift, w_shift_nxt;
    logic [N-1:0]     r_snap;
    logic [N-1:0]     w_frame;
    logic             r_first, r_latched, w_latched_nxt;
    logic             w_pend, w_load;
    logic             r_ds, r_shcp, r_stcp, r_oe_n, r_busy, r_done;

    // Reset synchroniser: assertion is immediate, release aligned to sys_clk.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Shift order on the wire: sel[0] first, sel[5], then seg[7] down to seg[0] last.
    always_comb begin
        w_frame            = '0;
        w_frame[SEL_W-1:0] = sel;
        for (int k = 0; k < SEG_W; k++) begin
            w_frame[SEL_W+k] = seg[SEG_W-1-k];
        end
    end

    assign w_pend = r_first | ({seg, sel} != r_snap);

    // Next-state and datapath update for the frame sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_bit_nxt     = r_bit;
        w_st_nxt      = r_st_cnt;
        w_shift_nxt   = r_shift;
        w_latched_nxt = r_latched;
        w_load        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_load      = 1'b1;
                w_shift_nxt = w_frame;
                w_phase_nxt = '0;
                w_bit_nxt   = '0;
                w_st_nxt    = '0;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (r_phase == PH_LAST) begin
                    w_phase_nxt = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = LATCH;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            LATCH: begin
                if (r_st_cnt == ST_LAST) begin
                    w_state_nxt   = IDLE;
                    w_latched_nxt = 1'b1;
                end else begin
                    w_st_nxt = r_st_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Sequencer state, counters, shift register and change-detect snapshot.
    always_ff @(posedge sys_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_bit     <= '0;
            r_st_cnt  <= '0;
            r_shift   <= '0;
            r_snap    <= '0;
            r_first   <= 1'b1;
            r_latched <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bit     <= w_bit_nxt;
            r_st_cnt  <= w_st_nxt;
            r_shift   <= w_shift_nxt;
            r_latched <= w_latched_nxt;
            if (w_load) begin
                r_snap  <= {seg, sel};
                r_first <= 1'b0;
            end else begin
                r_snap  <= r_snap;
                r_first <= r_first;
            end
        end
    end

    // Pin outputs are decoded from the next state so they flip on the same edge as the state.
    always_ff @(posedge sys_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ds   <= 1'b0;
            r_shcp <= 1'b0;
            r_stcp <= 1'b0;
            r_oe_n <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ds   <= (w_state_nxt == SHIFT) ? w_shift_nxt[0] : 1'b0;
            r_shcp <= (w_state_nxt == SHIFT) && (w_phase_nxt >= PH_HALF);
            r_stcp <= (w_state_nxt == LATCH);
            r_done <= (w_state_nxt == LATCH) && (w_st_nxt == ST_LAST);
            r_busy <= (w_state_nxt != IDLE);
            r_oe_n <= ~(out_en & w_latched_nxt);
        end
    end

    assign ds         = r_ds;
    assign shcp       = r_shcp;
    assign stcp       = r_stcp;
    assign oe_n       = r_oe_n;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
